// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word, arbiter state and arbiter side types.
package cpu_types_pkg;
    localparam int WORD_W = 32;
    typedef logic [WORD_W-1:0] word_t;
    typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} arb_state_t;
    typedef enum logic {SIDE_I, SIDE_D} arb_side_t;
endpackage

// File: rtl/arb_timer.sv
// arb_timer: saturating busy-cycle counter; expired flags TIMEOUT reached (never when TIMEOUT=0).
module arb_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic CLK,
    input  logic nRST,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    logic [W-1:0] r_cnt;
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) r_cnt <= '0;
        else if (clr) r_cnt <= '0;
        else if (en && r_cnt != W'(TIMEOUT)) r_cnt <= r_cnt + 1'b1;
    end
    assign expired = (TIMEOUT != 0) && (r_cnt == W'(TIMEOUT));
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises instruction and data accesses onto the single RAM port.
// Define ARB_RR_EN for round-robin arbitration instead of fixed data priority.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [DATA_W-1:0] iaddr,
    output logic [DATA_W-1:0] iload,
    output logic              ihit,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [DATA_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic [DATA_W-1:0] dload,
    output logic              dhit,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [DATA_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic              ramready,
    input  logic              ramerr,
    output logic              arb_err
);
    arb_state_t        r_state, w_next;
    logic [DATA_W-1:0] r_addr, r_store, r_iload, r_dload;
    logic              r_wr, r_ihit, r_dhit, r_err;
    logic              w_busy, w_arb, w_grant_d, w_grant_i, w_expired, w_abort, w_done;

    assign w_busy = r_state != IDLE;
    // The cycle carrying a hit/err pulse never arbitrates, so the requester can drop first.
    assign w_arb  = (r_state == IDLE) && !(r_ihit || r_dhit || r_err);
`ifdef ARB_RR_EN
    arb_side_t r_last;
    assign w_grant_d = w_arb && (dREN || dWEN) && (!iREN || r_last == SIDE_I);
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) r_last <= SIDE_I;
        else if (w_grant_d || w_grant_i) r_last <= w_grant_d ? SIDE_D : SIDE_I;
    end
`else
    assign w_grant_d = w_arb && (dREN || dWEN);
`endif
    assign w_grant_i = w_arb && iREN && !w_grant_d;
    assign w_abort   = w_busy && (ramerr || w_expired);
    assign w_done    = w_busy && ramready && !w_abort;

    arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .CLK    (CLK),
        .nRST   (nRST),
        .clr    (!w_busy),
        .en     (w_busy),
        .expired(w_expired)
    );

    always_comb begin
        w_next = r_state;
        w_next = w_grant_d ? DBUSY : w_grant_i ? IBUSY : (w_abort || w_done) ? IDLE : r_state;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_store <= '0;
            r_wr    <= 1'b0;
            r_iload <= '0;
            r_dload <= '0;
            r_ihit  <= 1'b0;
            r_dhit  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ihit  <= w_done && r_state == IBUSY;
            r_dhit  <= w_done && r_state == DBUSY;
            r_err   <= w_abort;
            if (w_done && r_state == IBUSY) r_iload <= ramload;
            if (w_done && r_state == DBUSY && !r_wr) r_dload <= ramload;
            if (w_grant_d || w_grant_i) begin
                r_addr  <= w_grant_d ? daddr : iaddr;
                r_store <= w_grant_d ? dstore : '0;
                r_wr    <= w_grant_d && dWEN;
            end
        end
    end

    assign ramREN   = w_busy && !r_wr;
    assign ramWEN   = w_busy && r_wr;
    assign ramaddr  = w_busy ? r_addr : '0;
    assign ramstore = w_busy ? r_store : '0;
    assign iload    = r_iload;
    assign dload    = r_dload;
    assign ihit     = r_ihit;
    assign dhit     = r_dhit;
    assign arb_err  = r_err;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized transaction bench for mem_arbiter with a transaction-level reference model.
module tb_mem_arbiter;
    localparam int TO = 4;
    logic        CLK = 1'b0, nRST = 1'b0;
    logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0, ramready = 1'b0, ramerr = 1'b0;
    logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic        ihit, dhit, ramREN, ramWEN, arb_err;
    int          n_chk = 0, n_err = 0;
    logic [31:0] exp_iload = '0, exp_dload = '0;
    bit          last_d = 1'b0;

    mem_arbiter #(.DATA_W(32), .TIMEOUT(TO)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dhit(dhit),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramready(ramready), .ramerr(ramerr), .arb_err(arb_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // kind: 0 ready after dly busy cycles, 1 ramerr, 2 ramerr+ramready, 3 no response (timeout)
    task automatic round(input bit wi, input bit wd, input bit wr, input logic [31:0] ia,
                         input logic [31:0] da, input logic [31:0] ds, input logic [31:0] rl,
                         input int kind, input int dly);
        bit pi, pd, win_d, wrx, ok;
        int n, nb;
        logic [31:0] ea, ld;
        @(negedge CLK);
        iREN = wi; iaddr = ia;
        dWEN = wd && wr; dREN = wd && (!wr || $urandom_range(0, 1) == 1);
        daddr = da; dstore = ds;
        pi = wi; pd = wd; ld = rl;
        while (pi || pd) begin
`ifdef ARB_RR_EN
            win_d = pd && (!pi || !last_d);
`else
            win_d = pd;
`endif
            last_d = win_d;
            ea = win_d ? da : ia;
            wrx = win_d && wr;
            n = 0;
            do begin
                @(negedge CLK);
                n++;
            end while (!(ramREN || ramWEN) && n < 8);
            chk("grant_lat", 32'(n), 32'd1);
            chk("ram_op", 32'({ramREN, ramWEN}), wrx ? 32'd1 : 32'd2);
            chk("ram_addr", ramaddr, ea);
            if (wrx) chk("ram_store", ramstore, ds);
            if (kind == 3) begin
                nb = 1; n = 0;
                while (!arb_err && n < 20) begin
                    @(negedge CLK);
                    n++;
                    if (ramREN || ramWEN) nb++;
                end
                chk("to_cycles", 32'(nb), 32'(TO + 1));
            end else begin
                for (int j = 0; j < dly; j++) begin
                    if (win_d) begin daddr = $urandom; dstore = $urandom; end
                    else iaddr = $urandom;
                    @(negedge CLK);
                    chk("ram_hold", ramaddr, ea);
                end
                ramready = kind != 1; ramerr = kind != 0; ramload = ld;
                @(negedge CLK);
                ramready = 1'b0; ramerr = 1'b0; ramload = $urandom;
            end
            ok = kind == 0;
            if (ok && !win_d) exp_iload = ld;
            if (ok && win_d && !wr) exp_dload = ld;
            chk("ihit", 32'(ihit), 32'(ok && !win_d));
            chk("dhit", 32'(dhit), 32'(ok && win_d));
            chk("arb_err", 32'(arb_err), 32'(!ok));
            chk("iload", iload, exp_iload);
            chk("dload", dload, exp_dload);
            chk("idle_ram", 32'({ramREN, ramWEN}), 32'd0);
            if (win_d) begin dREN = 1'b0; dWEN = 1'b0; pd = 1'b0; end
            else begin iREN = 1'b0; pi = 1'b0; end
            ld = ld ^ 32'h5A5A_1234;
            @(negedge CLK);
            chk("pulse_end", 32'({ihit, dhit, arb_err, ramREN, ramWEN}), 32'd0);
        end
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        chk("rst_out", 32'({ihit, dhit, arb_err, ramREN, ramWEN}), 32'd0);
        chk("rst_loads", iload | dload | ramaddr | ramstore, 32'd0);
        nRST = 1'b1;
        round(1, 0, 0, 32'h100, 0, 0, 32'h8C22_0004, 0, 1);
        round(0, 1, 1, 0, 32'h2000, 32'hDEAD_BEEF, $urandom, 0, 0);
        round(1, 1, 0, 32'h104, 32'h3000, 0, $urandom, 0, 2);
        round(1, 1, 0, 32'h108, 32'h3004, 0, $urandom, 0, 0);
        round(0, 1, 0, 0, 32'h3008, 0, $urandom, 3, 0);
        round(0, 1, 0, 0, 32'h3008, 0, $urandom, 0, 1);
        round(0, 1, 0, 0, 32'h300C, 0, $urandom, 2, 0);
        round(1, 0, 0, 32'h10C, 0, 0, $urandom, 1, 3);
        repeat (80) begin
            bit wi, wd;
            int k;
            wi = $urandom_range(0, 1) == 1; wd = $urandom_range(0, 1) == 1;
            if (!wi && !wd) wi = 1'b1;
            k = $urandom_range(0, 9);
            round(wi, wd, $urandom_range(0, 1) == 1, $urandom, $urandom, $urandom, $urandom,
                  k < 7 ? 0 : k - 6, $urandom_range(0, 3));
        end
        @(negedge CLK);
        dREN = 1'b1; daddr = 32'h44;
        @(negedge CLK);
        chk("mid_busy", 32'(ramREN), 32'd1);
        #2 nRST = 1'b0;
        #1;
        chk("mid_rst_ram", 32'({ramREN, ramWEN, dhit, ihit}), 32'd0);
        chk("mid_rst_addr", ramaddr, 32'd0);
        dREN = 1'b0;
        @(negedge CLK);
        nRST = 1'b1; ramready = 1'b1; ramload = 32'hCAFE_F00D;
        @(negedge CLK);
        ramready = 1'b0;
        exp_iload = '0; exp_dload = '0; last_d = 1'b0;
        chk("post_rst_hit", 32'({dhit, ihit, arb_err, ramREN, ramWEN}), 32'd0);
        chk("post_rst_dload", dload, exp_dload);
        round(1, 1, 0, 32'h200, 32'h4000, 0, $urandom, 0, 1);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
